axis_frame_gen: RTL and testbench
=================================

AXIS_FRAME_GEN -- requirements
Module: axis_frame_gen

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 32: data bits; SHALL equal 8*KEEP_W.
- KEEP_W, default (DATA_W+7)/8: byte lanes.
- ID_W, default 8: tid width.
- DST_W, default 8: tdest width.
- USR_W, default 1: tuser width.
- LEN_W, default 16: frame length field width, in bytes.

REQ-002 Ports SHALL be:
- clk  in  1  the single clock.
- arst  in  1  reset, asynchronous, active-high.
- start  in  1  frame request pulse.
- cfg_len  in  LEN_W  frame length in bytes.
- cfg_seed  in  8  first byte value.
- cfg_id  in  ID_W  tid for the frame.
- cfg_dest  in  DST_W  tdest for the frame.
- cfg_bad  in  1  mark the frame bad via tuser.
- m_axis_tdata  out  DATA_W  stream data.
- m_axis_tkeep  out  KEEP_W  byte enables.
- m_axis_tlast  out  1  end of frame.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tid  out  ID_W  stream id.
- m_axis_tdest  out  DST_W  stream dest.
- m_axis_tuser  out  USR_W  stream user.
- pause_req  in  1  stop at the next frame boundary.
- pause_ack  out  1  generator is paused.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when the last beat is accepted.
- stat_frames  out  32  count of completed frames.

Function
REQ-003 The state machine SHALL have states IDLE and SEND.
REQ-004 In IDLE, start=1 with pause_req=0 and cfg_len!=0 SHALL capture all cfg_* inputs and move to SEND; otherwise start SHALL be ignored.
REQ-005 cfg_* inputs SHALL be sampled only on an accepted start; later changes SHALL NOT affect the frame in flight.
REQ-006 m_axis_tvalid SHALL rise on the clock cycle immediately after the accepted start edge; all AXIS outputs SHALL be registered.
REQ-007 The beat count SHALL be ceil(cfg_len/KEEP_W).
REQ-008 Byte lane j of beat k SHALL be (cfg_seed + k*KEEP_W + j) mod 256.
REQ-009 tkeep SHALL be all ones on every beat except the last.
REQ-010 On the last beat, tkeep SHALL be the low (cfg_len mod KEEP_W) bits set, or all ones if the remainder is 0; bytes in unkept lanes SHALL be 0.
REQ-011 tlast SHALL be 1 only on the last beat.
REQ-012 tid and tdest SHALL hold the captured values for every beat of the frame.
REQ-013 tuser[0] SHALL equal the captured cfg_bad on the last beat and 0 on all other beats; the upper tuser bits SHALL be 0.
REQ-014 Once tvalid=1, tvalid and all payload outputs SHALL stay stable until a cycle with tvalid=1 and tready=1 (a handshake).
REQ-015 A new beat SHALL be presented in the cycle after each handshake, with no bubble (unless REQ-024 applies).
REQ-016 On the last-beat handshake, the block SHALL pulse done for 1 cycle, increment stat_frames (modulo 2^32) and return to IDLE with tvalid=0.
REQ-017 busy SHALL be 1 exactly while in SEND.
REQ-018 A back-to-back frame SHALL be possible: a start in the first IDLE cycle makes tvalid high one cycle later.
REQ-019 pause_req SHALL be honoured only in IDLE; a frame in SEND SHALL always complete.
REQ-020 pause_ack SHALL be 1 when the state is IDLE and pause_req=1, and 0 otherwise.
REQ-021 If pause_req and start are both 1 in IDLE, pause SHALL win and no frame SHALL start.
REQ-022 tready=0 for any number of cycles SHALL stall the block with no loss, duplication or change of data.

Reset
REQ-023 While arst=1, the block SHALL be in IDLE and tvalid, tlast, tdata, tkeep, tid, tdest, tuser, busy, done, pause_ack and stat_frames SHALL all be 0, with effect immediate and independent of clk. A frame interrupted by reset SHALL be abandoned, not resumed; the first start after reset SHALL produce a complete new frame.

Configuration
REQ-024 With AXIS_FRAME_GEN_GAP_EN defined, exactly one cycle with tvalid=0 SHALL follow every handshake except the last of a frame.
REQ-025 Without AXIS_FRAME_GEN_GAP_EN, beats SHALL be back-to-back as in REQ-015.
REQ-026 With AXIS_FRAME_GEN_GAP_EN, done, tlast and stat_frames behaviour SHALL be unchanged.

Verification
REQ-027 The bench SHALL cover these directed scenarios (DATA_W=32 unless stated):
- cfg_len=10, cfg_seed=0x00, tready=1 -> 3 beats: tdata 0x03020100, then 0x07060504, then 0x00000908; last tkeep=0011 with tlast=1; done pulses once; stat_frames=1.
- cfg_len=8, cfg_seed=0xFE, cfg_bad=1 -> beats 0x0100FFFE, then 0x05040302 with tkeep=1111 and tuser=1 on the last beat only.
- cfg_len=6, tready low for 5 cycles while tvalid=1 -> outputs held constant; after tready=1 both beats are delivered exactly once; total 2 handshakes.
- pause_req=1 raised mid-frame with cfg_len=12 -> all 3 beats complete, then pause_ack=1; start while paused -> tvalid stays 0; drop pause_req, pulse start -> frame starts.
- arst asserted after beat 1 of a 16-byte frame -> tvalid=0 and stat_frames=0 immediately; a new start yields 4 full beats from cfg_seed.
- AXIS_FRAME_GEN_GAP_EN defined, cfg_len=12, tready=1 -> tvalid pattern 1,0,1,0,1, then 0 after the last beat; cfg_len=0 start -> no tvalid, no done.

Source files
------------

// File: rtl/axis_frame_gen.sv
// AXI-Stream frame generator: emits cfg_len bytes of an incrementing byte pattern per start request.
// Optional AXIS_FRAME_GEN_GAP_EN inserts one idle cycle after every non-final beat handshake.
module axis_frame_gen #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = (DATA_W + 7) / 8,
    parameter int ID_W   = 8,
    parameter int DST_W  = 8,
    parameter int USR_W  = 1,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [7:0]        cfg_seed,
    input  logic [ID_W-1:0]   cfg_id,
    input  logic [DST_W-1:0]  cfg_dest,
    input  logic              cfg_bad,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [ID_W-1:0]   m_axis_tid,
    output logic [DST_W-1:0]  m_axis_tdest,
    output logic [USR_W-1:0]  m_axis_tuser,
    input  logic              pause_req,
    output logic              pause_ack,
    output logic              busy,
    output logic              done,
    output logic [31:0]       stat_frames
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q, state_d;
    logic [7:0]        nxt_byte_q, nxt_byte_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              bad_q, bad_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic [KEEP_W-1:0] tkeep_q, tkeep_d;
    logic              tlast_q, tlast_d;
    logic              tvalid_q, tvalid_d;
    logic [ID_W-1:0]   tid_q, tid_d;
    logic [DST_W-1:0]  tdest_q, tdest_d;
    logic [USR_W-1:0]  tuser_q, tuser_d;
    logic              done_q, done_d;
    logic [31:0]       stat_q, stat_d;
`ifdef AXIS_FRAME_GEN_GAP_EN
    logic              gap_q, gap_d;
`endif

    logic [7:0]        src_byte;
    logic [LEN_W-1:0]  src_rem;
    logic              src_bad;
    logic [DATA_W-1:0] beat_data;
    logic [KEEP_W-1:0] beat_keep;
    logic              beat_last;
    logic [USR_W-1:0]  beat_user;
    logic [LEN_W-1:0]  beat_rem;
    logic              load_beat;

    // Beat builder: in IDLE it works from the live cfg_* inputs (first beat),
    // in SEND from the captured running byte value and remaining byte count.
    always_comb begin
        src_byte = nxt_byte_q;
        src_rem  = rem_q;
        src_bad  = bad_q;
        if (state_q == IDLE) begin
            src_byte = cfg_seed;
            src_rem  = cfg_len;
            src_bad  = cfg_bad;
        end
        beat_keep = '0;
        beat_data = '0;
        for (int unsigned j = 0; j < KEEP_W; j++) begin
            if (src_rem > LEN_W'(j)) begin
                beat_keep[j]       = 1'b1;
                beat_data[j*8 +: 8] = src_byte + 8'(j);
            end
        end
        beat_last    = (src_rem <= LEN_W'(KEEP_W));
        beat_user    = '0;
        beat_user[0] = beat_last & src_bad;
        beat_rem     = src_rem - LEN_W'(KEEP_W);
    end

    always_comb begin
        state_d    = state_q;
        nxt_byte_d = nxt_byte_q;
        rem_d      = rem_q;
        bad_d      = bad_q;
        tdata_d    = tdata_q;
        tkeep_d    = tkeep_q;
        tlast_d    = tlast_q;
        tvalid_d   = tvalid_q;
        tid_d      = tid_q;
        tdest_d    = tdest_q;
        tuser_d    = tuser_q;
        done_d     = 1'b0;
        stat_d     = stat_q;
        load_beat  = 1'b0;
`ifdef AXIS_FRAME_GEN_GAP_EN
        gap_d      = gap_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !pause_req && (cfg_len != '0)) begin
                    state_d   = SEND;
                    tid_d     = cfg_id;
                    tdest_d   = cfg_dest;
                    bad_d     = cfg_bad;
                    load_beat = 1'b1;
                end
            end
            SEND: begin
                if (tvalid_q && m_axis_tready) begin
                    if (tlast_q) begin
                        state_d  = IDLE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tdata_d  = '0;
                        tkeep_d  = '0;
                        tuser_d  = '0;
                        tid_d    = '0;
                        tdest_d  = '0;
                        done_d   = 1'b1;
                        stat_d   = stat_q + 32'd1;
                    end else begin
`ifdef AXIS_FRAME_GEN_GAP_EN
                        tvalid_d = 1'b0;
                        gap_d    = 1'b1;
`else
                        load_beat = 1'b1;
`endif
                    end
                end
`ifdef AXIS_FRAME_GEN_GAP_EN
                else if (gap_q) begin
                    gap_d     = 1'b0;
                    load_beat = 1'b1;
                end
`endif
            end
        endcase
        if (load_beat) begin
            tdata_d    = beat_data;
            tkeep_d    = beat_keep;
            tlast_d    = beat_last;
            tuser_d    = beat_user;
            tvalid_d   = 1'b1;
            rem_d      = beat_rem;
            nxt_byte_d = src_byte + 8'(KEEP_W);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= IDLE;
            nxt_byte_q <= '0;
            rem_q      <= '0;
            bad_q      <= 1'b0;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b0;
            tid_q      <= '0;
            tdest_q    <= '0;
            tuser_q    <= '0;
            done_q     <= 1'b0;
            stat_q     <= '0;
`ifdef AXIS_FRAME_GEN_GAP_EN
            gap_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            nxt_byte_q <= nxt_byte_d;
            rem_q      <= rem_d;
            bad_q      <= bad_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            tlast_q    <= tlast_d;
            tvalid_q   <= tvalid_d;
            tid_q      <= tid_d;
            tdest_q    <= tdest_d;
            tuser_q    <= tuser_d;
            done_q     <= done_d;
            stat_q     <= stat_d;
`ifdef AXIS_FRAME_GEN_GAP_EN
            gap_q      <= gap_d;
`endif
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tid    = tid_q;
    assign m_axis_tdest  = tdest_q;
    assign m_axis_tuser  = tuser_q;
    assign busy          = (state_q == SEND);
    assign done          = done_q;
    assign stat_frames   = stat_q;
    // Gated by arst so the acknowledge is low during reset even if pause_req is held.
    assign pause_ack     = (state_q == IDLE) && pause_req && !arst;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Self-checking bench for axis_frame_gen: frame-level reference model plus directed literal checks.
// Build with AXIS_FRAME_GEN_GAP_EN defined to exercise the inter-beat gap variant.
module tb_axis_frame_gen;

    localparam int DW  = 32;
    localparam int KW  = 4;
    localparam int IW  = 8;
    localparam int DSW = 8;
    localparam int UW  = 1;
    localparam int LW  = 16;
`ifdef AXIS_FRAME_GEN_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          arst;
    logic          start;
    logic [LW-1:0] cfg_len;
    logic [7:0]    cfg_seed;
    logic [IW-1:0] cfg_id;
    logic [DSW-1:0] cfg_dest;
    logic          cfg_bad;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [IW-1:0] m_axis_tid;
    logic [DSW-1:0] m_axis_tdest;
    logic [UW-1:0] m_axis_tuser;
    logic          pause_req;
    logic          pause_ack;
    logic          busy;
    logic          done;
    logic [31:0]   stat_frames;

    axis_frame_gen #(
        .DATA_W(DW), .KEEP_W(KW), .ID_W(IW), .DST_W(DSW), .USR_W(UW), .LEN_W(LW)
    ) dut (
        .clk(clk), .arst(arst), .start(start), .cfg_len(cfg_len), .cfg_seed(cfg_seed),
        .cfg_id(cfg_id), .cfg_dest(cfg_dest), .cfg_bad(cfg_bad),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tid(m_axis_tid),
        .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser), .pause_req(pause_req),
        .pause_ack(pause_ack), .busy(busy), .done(done), .stat_frames(stat_frames)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]  data;
        logic [KW-1:0]  keep;
        logic           last;
        logic [UW-1:0]  user;
        logic [IW-1:0]  id;
        logic [DSW-1:0] dest;
    } beat_t;

    beat_t exp_q[$];
    beat_t hs_log[$];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    bit          m_in_frame = 1'b0;
    bit          m_gap = 1'b0;
    bit          m_done = 1'b0;
    int unsigned m_frames = 0;
    bit          m_exp_v;
    bit          m_idle;
    beat_t       m_b;
    beat_t       m_h;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: expand a frame request into its beats straight from the byte-stream rules.
    function automatic void build_frame(int unsigned len, logic [7:0] seed,
                                        logic [IW-1:0] id, logic [DSW-1:0] dest, logic bad);
        int unsigned nb;
        beat_t b;
        nb = (len + KW - 1) / KW;
        for (int unsigned k = 0; k < nb; k++) begin
            b.data = '0;
            b.keep = '0;
            for (int unsigned j = 0; j < KW; j++) begin
                if (k * KW + j < len) begin
                    b.keep[j] = 1'b1;
                    b.data[j*8 +: 8] = 8'((seed + k * KW + j) % 256);
                end
            end
            b.last = (k == nb - 1);
            b.user = (k == nb - 1) ? UW'(bad) : '0;
            b.id   = id;
            b.dest = dest;
            exp_q.push_back(b);
        end
    endfunction

    // Single compare process: outputs are checked at every falling edge.
    always @(negedge clk) begin
        if (arst) begin
            chk("rst_tvalid", m_axis_tvalid, 0);
            chk("rst_tlast", m_axis_tlast, 0);
            chk("rst_tdata", m_axis_tdata, 0);
            chk("rst_tkeep", m_axis_tkeep, 0);
            chk("rst_tid", m_axis_tid, 0);
            chk("rst_tdest", m_axis_tdest, 0);
            chk("rst_tuser", m_axis_tuser, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_pause_ack", pause_ack, 0);
            chk("rst_stat", stat_frames, 0);
            m_in_frame = 1'b0;
            m_gap      = 1'b0;
            m_done     = 1'b0;
            m_frames   = 0;
            exp_q.delete();
        end else begin
            m_exp_v = m_in_frame && !m_gap;
            chk("tvalid", m_axis_tvalid, m_exp_v);
            chk("busy", busy, m_in_frame);
            chk("done", done, m_done);
            chk("stat_frames", stat_frames, m_frames);
            chk("pause_ack", pause_ack, !m_in_frame && pause_req);
            if (m_exp_v && exp_q.size() > 0) begin
                m_b = exp_q[0];
                chk("tdata", m_axis_tdata, m_b.data);
                chk("tkeep", m_axis_tkeep, m_b.keep);
                chk("tlast", m_axis_tlast, m_b.last);
                chk("tuser", m_axis_tuser, m_b.user);
                chk("tid", m_axis_tid, m_b.id);
                chk("tdest", m_axis_tdest, m_b.dest);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                m_h.data = m_axis_tdata; m_h.keep = m_axis_tkeep; m_h.last = m_axis_tlast;
                m_h.user = m_axis_tuser; m_h.id = m_axis_tid; m_h.dest = m_axis_tdest;
                hs_log.push_back(m_h);
            end
            if (done) done_cnt++;
            // Predict the state after the coming rising edge.
            m_idle = !m_in_frame;
            m_done = 1'b0;
            if (m_exp_v && m_axis_tready && exp_q.size() > 0) begin
                m_b = exp_q.pop_front();
                if (m_b.last) begin
                    m_in_frame = 1'b0;
                    m_frames++;
                    m_done = 1'b1;
                end else begin
                    m_gap = GAP;
                end
            end else begin
                m_gap = 1'b0;
            end
            if (m_idle && start && !pause_req && cfg_len != '0) begin
                build_frame(int'(cfg_len), cfg_seed, cfg_id, cfg_dest, cfg_bad);
                m_in_frame = 1'b1;
                m_gap = 1'b0;
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_frame(int unsigned len, logic [7:0] seed, logic [IW-1:0] id,
                               logic [DSW-1:0] dest, logic bad);
        cfg_len = LW'(len); cfg_seed = seed; cfg_id = id; cfg_dest = dest; cfg_bad = bad;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(int target, int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        chk("wait_done", done_cnt, target);
    endtask

    int d0;
    int hs0;
    logic [5:0] pat;
    logic [5:0] pat_exp;
    logic seen_v;

    initial begin
        arst = 1'b1; start = 1'b0; cfg_len = '0; cfg_seed = '0; cfg_id = '0; cfg_dest = '0;
        cfg_bad = 1'b0; m_axis_tready = 1'b1; pause_req = 1'b0;
        tick(3);
        arst = 1'b0;
        tick(2);

        // 10 bytes from seed 0: three beats, short last beat
        hs_log.delete(); d0 = done_cnt;
        start_frame(10, 8'h00, 8'h11, 8'h22, 1'b0);
        wait_done(d0 + 1, 50);
        tick(2);
        chk("s1_beats", hs_log.size(), 3);
        if (hs_log.size() == 3) begin
            chk("s1_d0", hs_log[0].data, 32'h03020100);
            chk("s1_d1", hs_log[1].data, 32'h07060504);
            chk("s1_d2", hs_log[2].data, 32'h00000908);
            chk("s1_keep2", hs_log[2].keep, 4'b0011);
            chk("s1_last2", hs_log[2].last, 1);
            chk("s1_last1", hs_log[1].last, 0);
        end
        chk("s1_done_once", done_cnt - d0, 1);
        chk("s1_stat", stat_frames, 1);

        // seed wrap and bad frame marking
        hs_log.delete(); d0 = done_cnt;
        start_frame(8, 8'hFE, 8'h33, 8'h44, 1'b1);
        wait_done(d0 + 1, 50);
        chk("s2_beats", hs_log.size(), 2);
        if (hs_log.size() == 2) begin
            chk("s2_d0", hs_log[0].data, 32'h0100FFFE);
            chk("s2_d1", hs_log[1].data, 32'h05040302);
            chk("s2_keep1", hs_log[1].keep, 4'hF);
            chk("s2_user0", hs_log[0].user, 0);
            chk("s2_user1", hs_log[1].user, 1);
        end

        // back-pressure: tready low for 5 cycles with tvalid up
        hs_log.delete(); d0 = done_cnt;
        m_axis_tready = 1'b0;
        start_frame(6, 8'h10, 8'h01, 8'h02, 1'b0);
        tick(5);
        chk("s3_held_data", m_axis_tdata, 32'h13121110);
        chk("s3_no_hs", hs_log.size(), 0);
        m_axis_tready = 1'b1;
        wait_done(d0 + 1, 50);
        chk("s3_beats", hs_log.size(), 2);
        if (hs_log.size() == 2) begin
            chk("s3_d1", hs_log[1].data, 32'h00001514);
            chk("s3_keep1", hs_log[1].keep, 4'b0011);
        end

        // pause requested mid-frame: the frame completes, then the block parks
        hs_log.delete(); d0 = done_cnt;
        start_frame(12, 8'h20, 8'h05, 8'h06, 1'b0);
        pause_req = 1'b1;
        wait_done(d0 + 1, 50);
        tick(1);
        chk("s4_beats", hs_log.size(), 3);
        chk("s4_pause_ack", pause_ack, 1);
        start_frame(8, 8'h30, 8'h07, 8'h08, 1'b0);
        tick(3);
        chk("s4_paused_tvalid", m_axis_tvalid, 0);
        chk("s4_paused_busy", busy, 0);
        pause_req = 1'b0;
        start_frame(8, 8'h30, 8'h07, 8'h08, 1'b0);
        wait_done(d0 + 2, 50);
        chk("s4_total_beats", hs_log.size(), 5);

        // reset after first beat of a 16-byte frame
        start_frame(16, 8'h40, 8'h09, 8'h0A, 1'b0);
        tick(1);
        arst = 1'b1;
        #1;
        chk("s5_rst_tvalid", m_axis_tvalid, 0);
        chk("s5_rst_stat", stat_frames, 0);
        tick(2);
        arst = 1'b0;
        tick(1);
        hs_log.delete(); d0 = done_cnt;
        start_frame(16, 8'h40, 8'h09, 8'h0A, 1'b0);
        wait_done(d0 + 1, 50);
        chk("s5_beats", hs_log.size(), 4);
        if (hs_log.size() == 4) begin
            chk("s5_d0", hs_log[0].data, 32'h43424140);
            chk("s5_d3", hs_log[3].data, 32'h4F4E4D4C);
            chk("s5_keep3", hs_log[3].keep, 4'hF);
        end
        chk("s5_stat", stat_frames, 1);

        // tvalid pattern for a 12-byte frame, then a zero-length request
        tick(1);
        d0 = done_cnt;
        start_frame(12, 8'h50, 8'h0B, 8'h0C, 1'b0);
        for (int i = 0; i < 6; i++) begin
            pat[5 - i] = m_axis_tvalid;
            tick(1);
        end
`ifdef AXIS_FRAME_GEN_GAP_EN
        pat_exp = 6'b101010;
`else
        pat_exp = 6'b111000;
`endif
        chk("s6_tvalid_pattern", pat, pat_exp);
        wait_done(d0 + 1, 20);
        d0 = done_cnt;
        start_frame(0, 8'h60, 8'h0D, 8'h0E, 1'b0);
        seen_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seen_v = seen_v | m_axis_tvalid;
            tick(1);
        end
        chk("s6_len0_tvalid", seen_v, 0);
        chk("s6_len0_done", done_cnt, d0);

        // randomized traffic: back-pressure, pauses, stray starts, cfg churn in flight
        hs0 = hs_log.size();
        for (int c = 0; c < 1500; c++) begin
            m_axis_tready = ($urandom % 10) < 7;
            pause_req     = ($urandom % 20) == 0;
            start         = ($urandom % 4) == 0;
            cfg_len       = LW'($urandom_range(0, 40));
            cfg_seed      = 8'($urandom);
            cfg_id        = IW'($urandom);
            cfg_dest      = DSW'($urandom);
            cfg_bad       = 1'($urandom);
            tick(1);
        end
        start = 1'b0; pause_req = 1'b0; m_axis_tready = 1'b1;
        for (int n = 0; n < 100 && busy; n++) tick(1);
        tick(2);
        chk("rand_idle", busy, 0);
        chk("rand_model_drained", exp_q.size(), 0);
        chk("rand_traffic_seen", hs_log.size() > hs0 + 50, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
